// File: rtl/video_cap_pkg.sv
// Shared types for the video line capture block: FSM states, bank descriptor,
// and the width rule for length and line-number fields.
package video_cap_pkg;

  // Descriptor fields are stored at a fixed width and narrowed to LW at use.
  localparam int unsigned DESC_W = 16;

  typedef enum logic [1:0] {W_IDLE, W_CAP, W_DROP} w_state_e;
  typedef enum logic {R_IDLE, R_STREAM} r_state_e;

  typedef struct packed {
    logic              full;
    logic [DESC_W-1:0] len;
    logic [DESC_W-1:0] line;
  } bank_desc_t;

  function automatic int unsigned calc_lw(input int unsigned max_pix);
    return $clog2(max_pix) + 1;
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Simple dual-port line buffer bank: one write port, one registered read port
// with a single cycle of read latency.
module line_bank_ram #(
  parameter int unsigned DSIZE = 24,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/video_line_capture.sv
// Captures de-framed pixel lines into a ping-pong line buffer and replays each
// completed line on a valid/ready stream tagged with its length and line index.
module video_line_capture
  import video_cap_pkg::*;
#(
  parameter int unsigned DSIZE   = 24,
  parameter int unsigned MAX_PIX = 2048,
  parameter int unsigned LW      = calc_lw(MAX_PIX)
) (
  input  logic             i_pclk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_de,
  input  logic [DSIZE-1:0] i_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [DSIZE-1:0] o_out_data,
  output logic             o_out_last,
  output logic [LW-1:0]    o_out_len,
  output logic [LW-1:0]    o_out_line,
  output logic             o_trunc_err,
  output logic             o_len_err,
  output logic             o_ovf_err,
  input  logic             i_err_clr
);

  localparam int unsigned AW = LW - 1;
  localparam logic [LW-1:0] CAP_LEN = LW'(MAX_PIX);

  w_state_e         r_w_state, w_w_state_nxt;
  r_state_e         r_r_state, w_r_state_nxt;
  bank_desc_t       r_bank [2];
  logic             r_wbank, r_rbank;
  logic [LW-1:0]    r_wcnt, r_cur_line, r_line_cnt, r_ref_len;
  logic             r_ref_valid, r_vsync_q, r_de_q;
  logic             r_trunc, r_ovf, r_len_err;
  logic [AW-1:0]    r_rd_idx;

  logic             w_we, w_start, w_drop, w_over, w_done;
  logic [AW-1:0]    w_waddr, w_raddr;
  logic             w_vsync_rise, w_ref_load, w_wbank_free;
  logic             w_stream, w_rd_fire, w_rd_last, w_rd_free;
  logic [LW-1:0]    w_rd_len;
  logic [DSIZE-1:0] w_rdata0, w_rdata1, w_rdata;

  assign w_vsync_rise = i_vsync && !r_vsync_q;
  assign w_stream     = (r_r_state == R_STREAM);
  assign w_rd_len     = LW'(r_bank[r_rbank].len);
  assign w_rd_last    = ({1'b0, r_rd_idx} == (w_rd_len - LW'(1)));
  assign w_rd_fire    = w_stream && i_out_ready;
  assign w_rd_free    = w_rd_fire && w_rd_last;
  // A bank being released by the reader in this very cycle counts as free.
  assign w_wbank_free = !r_bank[r_wbank].full || (w_rd_free && (r_rbank == r_wbank));
  assign w_ref_load   = w_done && (r_cur_line == '0) && !w_vsync_rise;

  // Write FSM
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_start       = 1'b0;
    w_drop        = 1'b0;
    w_over        = 1'b0;
    w_done        = 1'b0;
    unique case (r_w_state)
      W_IDLE: begin
        // r_de_q resets high so a line already in progress at reset release is ignored.
        if (i_de && !r_de_q) begin
          if (w_wbank_free) begin
            w_w_state_nxt = W_CAP;
            w_we          = 1'b1;
            w_start       = 1'b1;
          end else begin
            w_w_state_nxt = W_DROP;
            w_drop        = 1'b1;
          end
        end
      end
      W_CAP: begin
        if (i_de) begin
          if (r_wcnt < CAP_LEN) begin
            w_we    = 1'b1;
            w_waddr = r_wcnt[AW-1:0];
          end else begin
            w_over = 1'b1;
          end
        end else begin
          w_done        = 1'b1;
          w_w_state_nxt = W_IDLE;
        end
      end
      W_DROP: begin
        if (!i_de) begin
          w_w_state_nxt = W_IDLE;
        end
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w_state   <= W_IDLE;
      r_wbank     <= 1'b0;
      r_wcnt      <= '0;
      r_cur_line  <= '0;
      r_line_cnt  <= '0;
      r_ref_len   <= '0;
      r_ref_valid <= 1'b0;
      r_vsync_q   <= 1'b0;
      r_de_q      <= 1'b1;
      r_trunc     <= 1'b0;
      r_ovf       <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_vsync_q <= i_vsync;
      r_de_q    <= i_de;
      if (w_start) begin
        r_wcnt     <= LW'(1);
        r_cur_line <= r_line_cnt;
      end else if (w_we) begin
        r_wcnt <= r_wcnt + LW'(1);
      end
      // The index is taken at line start, so a vsync mid-line leaves it untouched.
      if (w_vsync_rise) begin
        r_line_cnt <= '0;
      end else if (w_start || w_drop) begin
        r_line_cnt <= r_line_cnt + LW'(1);
      end
      if (w_vsync_rise) begin
        r_ref_valid <= 1'b0;
      end else if (w_ref_load) begin
        r_ref_valid <= 1'b1;
        r_ref_len   <= r_wcnt;
      end
      r_len_err <= w_done && !w_ref_load && r_ref_valid && (r_wcnt != r_ref_len);
      if (w_done) begin
        r_wbank <= ~r_wbank;
      end
      if (w_over) begin
        r_trunc <= 1'b1;
      end else if (i_err_clr) begin
        r_trunc <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_err_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Bank descriptors: set by the writer on completion, cleared by the reader.
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_done && (r_wbank == 1'(i))) begin
          r_bank[i].full <= 1'b1;
          r_bank[i].len  <= DESC_W'(r_wcnt);
          r_bank[i].line <= DESC_W'(r_cur_line);
        end else if (w_rd_free && (r_rbank == 1'(i))) begin
          r_bank[i].full <= 1'b0;
        end
      end
    end
  end

  // Read FSM; the RAM address runs one pixel ahead on each accepted beat.
  always_comb begin
    w_r_state_nxt = r_r_state;
    w_raddr       = r_rd_idx;
    unique case (r_r_state)
      R_IDLE: begin
        w_raddr = '0;
        if (r_bank[r_rbank].full) begin
          w_r_state_nxt = R_STREAM;
        end
      end
      R_STREAM: begin
        if (w_rd_fire) begin
          if (w_rd_last) begin
            w_r_state_nxt = R_IDLE;
          end else begin
            w_raddr = r_rd_idx + AW'(1);
          end
        end
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_r_state <= R_IDLE;
      r_rbank   <= 1'b0;
      r_rd_idx  <= '0;
    end else begin
      r_r_state <= w_r_state_nxt;
      if (w_rd_free) begin
        r_rbank  <= ~r_rbank;
        r_rd_idx <= '0;
      end else if (w_rd_fire) begin
        r_rd_idx <= r_rd_idx + AW'(1);
      end
    end
  end

  line_bank_ram #(
    .DSIZE (DSIZE),
    .DEPTH (MAX_PIX),
    .AW    (AW)
  ) u_bank0 (
    .i_clk   (i_pclk),
    .i_we    (w_we && !r_wbank),
    .i_waddr (w_waddr),
    .i_wdata (i_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata0)
  );

  line_bank_ram #(
    .DSIZE (DSIZE),
    .DEPTH (MAX_PIX),
    .AW    (AW)
  ) u_bank1 (
    .i_clk   (i_pclk),
    .i_we    (w_we && r_wbank),
    .i_waddr (w_waddr),
    .i_wdata (i_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata1)
  );

  assign w_rdata = r_rbank ? w_rdata1 : w_rdata0;

  // Stream fields are forced to zero outside a replay so reset clears them at once.
  assign o_out_valid = w_stream;
  assign o_out_data  = w_stream ? w_rdata : '0;
  assign o_out_last  = w_stream && w_rd_last;
  assign o_out_len   = w_stream ? w_rd_len : '0;
  assign o_out_line  = w_stream ? LW'(r_bank[r_rbank].line) : '0;
  assign o_trunc_err = r_trunc;
  assign o_len_err   = r_len_err;
  assign o_ovf_err   = r_ovf;

endmodule

// File: tb/tb_video_line_capture.sv
// Bench for video_line_capture: directed line stimulus, a line-level reference
// model with a per-cycle compare process, and literal spot checks.
module tb_video_line_capture;

  localparam int unsigned DSIZE = 16;
  localparam int unsigned MAXP  = 32;
  localparam int unsigned LW    = $clog2(MAXP) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vsync = 1'b0;
  logic             de = 1'b0;
  logic [DSIZE-1:0] data = '0;
  logic             out_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic             out_valid, out_last, trunc_err, len_err, ovf_err;
  logic [DSIZE-1:0] out_data;
  logic [LW-1:0]    out_len, out_line;

  video_line_capture #(
    .DSIZE   (DSIZE),
    .MAX_PIX (MAXP)
  ) dut (
    .i_pclk      (clk),
    .i_rst_n     (rst_n),
    .i_vsync     (vsync),
    .i_de        (de),
    .i_data      (data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_out_len   (out_len),
    .o_out_line  (out_line),
    .o_trunc_err (trunc_err),
    .o_len_err   (len_err),
    .o_ovf_err   (ovf_err),
    .i_err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: lines are whole objects; a line is kept if fewer than two
  // lines are stored or unread, counting a line whose last beat is taken now.
  typedef struct {
    logic [DSIZE-1:0] d;
    bit               last;
    int               len;
    int               line;
  } beat_t;

  beat_t            exp_q[$];
  logic [DSIZE-1:0] cur_pix[$];
  int  m_occ = 0, m_line_cnt = 0, m_cur_line = 0, m_ref = 0, m_pixcnt = 0;
  bit  m_ref_ok = 0, m_in_line = 0, m_accept = 0, m_prev_vs = 0;
  bit  m_trunc = 0, m_ovf = 0, m_len_err = 0;
  bit  p_stall = 0;
  logic [DSIZE-1:0] pv_data;
  logic             pv_last;
  logic [LW-1:0]    pv_len, pv_line;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("valid_in_reset", 32'(out_valid), 0);
      exp_q.delete();
      cur_pix.delete();
      m_occ = 0; m_line_cnt = 0; m_ref_ok = 0; m_in_line = 0; m_prev_vs = 0;
      m_trunc = 0; m_ovf = 0; m_len_err = 0; p_stall = 0;
    end else begin
      check("trunc_err", 32'(trunc_err), 32'(m_trunc));
      check("ovf_err", 32'(ovf_err), 32'(m_ovf));
      check("len_err", 32'(len_err), 32'(m_len_err));
      if (p_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(pv_data));
        check("stall_last", 32'(out_last), 32'(pv_last));
        check("stall_len", 32'(out_len), 32'(pv_len));
        check("stall_line", 32'(out_line), 32'(pv_line));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %0d, expected no beat", out_data);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(b.d));
          check("beat_last", 32'(out_last), 32'(b.last));
          check("beat_len", 32'(out_len), 32'(b.len));
          check("beat_line", 32'(out_line), 32'(b.line));
          if (b.last) m_occ--;
        end
      end
      p_stall = out_valid && !out_ready;
      pv_data = out_data; pv_last = out_last; pv_len = out_len; pv_line = out_line;

      m_len_err = 0;
      if (err_clr) begin
        m_trunc = 0;
        m_ovf = 0;
      end
      if (!m_in_line && de) begin
        m_in_line = 1;
        m_cur_line = m_line_cnt;
        m_line_cnt++;
        m_pixcnt = 0;
        cur_pix.delete();
        if (m_occ < 2) begin
          m_accept = 1;
          m_occ++;
        end else begin
          m_accept = 0;
          m_ovf = 1;
        end
      end
      if (m_in_line && de && m_accept) begin
        if (m_pixcnt < MAXP) cur_pix.push_back(data);
        else m_trunc = 1;
        m_pixcnt++;
      end
      if (m_in_line && !de) begin
        m_in_line = 0;
        if (m_accept) begin
          int n;
          n = cur_pix.size();
          for (int i = 0; i < n; i++) begin
            beat_t nb;
            nb.d = cur_pix[i]; nb.last = (i == n - 1); nb.len = n; nb.line = m_cur_line;
            exp_q.push_back(nb);
          end
          if (m_cur_line == 0) begin
            m_ref = n;
            m_ref_ok = 1;
          end else if (m_ref_ok && n != m_ref) begin
            m_len_err = 1;
          end
        end
      end
      if (vsync && !m_prev_vs) begin
        m_line_cnt = 0;
        m_ref_ok = 0;
      end
      m_prev_vs = vsync;
    end
  end

  // Beat log for literal checks on line tags and counts.
  int n_beats = 0, n_lenerr = 0;
  logic [DSIZE-1:0] last_data;
  int line_log[$];
  int len_log[$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_beats++;
      last_data = out_data;
      if (out_last) begin
        line_log.push_back(int'(out_line));
        len_log.push_back(int'(out_len));
      end
    end
    if (rst_n && len_err) n_lenerr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input int base, input int gap, input bit rnd);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      data = DSIZE'(base + i);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    de = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic drain(input bit rnd);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid || m_in_line) && k < 3000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    if (k >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    int b0;
    // Reset values
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_len", 32'(out_len), 0);
    check("rst_errs", {29'd0, trunc_err, len_err, ovf_err}, 0);
    rst_n = 1'b1;
    tick();

    // 16-pixel line, exact replay latency and gapless stream
    out_ready = 1'b1;
    send_line(16, 0, 0, 0);
    tick();
    check("t1_valid_t+1", 32'(out_valid), 0);
    tick();
    for (int i = 0; i < 16; i++) begin
      check("t1_valid", 32'(out_valid), 1);
      check("t1_data", 32'(out_data), i);
      check("t1_last", 32'(out_last), (i == 15) ? 1 : 0);
      if (i == 0) begin
        check("t1_len", 32'(out_len), 16);
        check("t1_line", 32'(out_line), 0);
      end
      tick();
    end
    check("t1_valid_after", 32'(out_valid), 0);
    drain(0);

    // Three lines in a new frame; the short third line flags a length error
    vsync_pulse();
    line_log.delete();
    n_lenerr = 0;
    send_line(8, 100, 2, 0);
    send_line(8, 200, 2, 0);
    send_line(5, 300, 2, 0);
    drain(0);
    check("t2_lenerr_pulses", n_lenerr, 1);
    check("t2_lines", line_log.size(), 3);
    if (line_log.size() == 3) begin
      check("t2_line0", line_log[0], 0);
      check("t2_line1", line_log[1], 1);
      check("t2_line2", line_log[2], 2);
    end

    // Stalled output: two lines stored, the third dropped
    vsync_pulse();
    line_log.delete();
    out_ready = 1'b0;
    b0 = n_beats;
    send_line(4, 400, 1, 0);
    send_line(4, 410, 1, 0);
    send_line(4, 420, 1, 0);
    repeat (3) tick();
    check("t3_ovf", 32'(ovf_err), 1);
    out_ready = 1'b1;
    drain(0);
    check("t3_beats", n_beats - b0, 8);
    check("t3_nlines", line_log.size(), 2);
    if (line_log.size() == 2) check("t3_line1", line_log[1], 1);
    check("t3_lastdata", 32'(last_data), 413);

    // Overlong line truncates at capacity, then a single-pixel line
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vsync_pulse();
    check("t4_clr_ovf", 32'(ovf_err), 0);
    len_log.delete();
    b0 = n_beats;
    send_line(40, 500, 2, 0);
    check("t4_trunc", 32'(trunc_err), 1);
    drain(0);
    check("t4_beats", n_beats - b0, 32);
    check("t4_lastdata", 32'(last_data), 531);
    send_line(1, 777, 2, 0);
    drain(0);
    check("t4_nlens", len_log.size(), 2);
    if (len_log.size() == 2) begin
      check("t4_len0", len_log[0], 32);
      check("t4_len1", len_log[1], 1);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr_trunc", 32'(trunc_err), 0);

    // Random backpressure over ten full-capacity lines
    vsync_pulse();
    b0 = n_beats;
    for (int l = 0; l < 10; l++) begin
      send_line(32, 1000 + 32 * l, 64, 1);
    end
    drain(1);
    check("t5_beats", n_beats - b0, 320);
    check("t5_ovf", 32'(ovf_err), 0);

    // Reset in the middle of a replay
    out_ready = 1'b1;
    send_line(16, 2000, 0, 0);
    repeat (7) tick();
    check("t6_valid_before", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t6_valid_rst", 32'(out_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_line(6, 3000, 0, 0);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("t6_valid_seen", 32'(out_valid), 1);
    check("t6_line", 32'(out_line), 0);
    check("t6_len", 32'(out_len), 6);
    check("t6_data", 32'(out_data), 3000);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
